// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr request at a time against the
// machine-mode CSR file. It reads the CSR, waits a cycle for the registered
// read data, then computes the read-modify-write result. It issues the write
// and returns the old value, or flags the request as illegal.
module csr_access_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_OP,
  input  logic        REQ_USE_IMM,
  input  logic [11:0] REQ_CSR_ADDR,
  input  logic [4:0]  REQ_RS1_ADDR,
  input  logic [31:0] REQ_RS1_DATA,
  input  logic [4:0]  REQ_UIMM,
  input  logic [4:0]  REQ_RD_ADDR,
  output logic [11:0] CSR_RADDR,
  input  logic [31:0] CSR_RDATA_REG,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        RESP_VALID,
  output logic [4:0]  RESP_RD_ADDR,
  output logic [31:0] RESP_RD_DATA,
  output logic        RESP_ILLEGAL
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic        illegal_q;
  logic [31:0] old_q;

  logic [31:0] req_src;
  logic        req_wen;
  logic        req_rw_csr;
  logic        req_ro_csr;
  logic        req_illegal;
  logic        accept;
  logic [31:0] new_val;
  logic        write_fire;

  // Decode the incoming request so legality and write enable are fixed at accept time
  always_comb begin
    req_src    = REQ_USE_IMM ? {27'b0, REQ_UIMM} : REQ_RS1_DATA;
    req_wen    = (REQ_OP == OP_RW) ||
                 (REQ_USE_IMM ? (REQ_UIMM != 5'd0) : (REQ_RS1_ADDR != 5'd0));
    req_rw_csr = 1'b0;
    req_ro_csr = 1'b0;
    case (REQ_CSR_ADDR)
      12'h305, 12'h340, 12'h341, 12'h342, 12'h343: req_rw_csr = 1'b1;
      12'hB00, 12'hB80, 12'hB02, 12'hB82:          req_ro_csr = 1'b1;
      default: ;
    endcase
    req_illegal = (REQ_OP == 2'b00) || !(req_rw_csr || req_ro_csr) ||
                  (req_wen && req_ro_csr);
  end

  assign REQ_READY = (state_q == ST_IDLE) && !FLUSH && !RST;
  assign accept    = REQ_VALID && REQ_READY;

  // Advance IDLE -> READ -> WRITE -> RESP -> IDLE; a flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = ST_READ;
        ST_READ:  state_d = ST_WRITE;
        ST_WRITE: state_d = ST_RESP;
        ST_RESP:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Combine the freshly read CSR value with the latched source operand
  always_comb begin
    case (op_q)
      OP_RW:   new_val = src_q;
      OP_RS:   new_val = CSR_RDATA_REG | src_q;
      OP_RC:   new_val = CSR_RDATA_REG & ~src_q;
      default: new_val = src_q;
    endcase
  end

  assign write_fire   = (state_q == ST_WRITE) && wen_q && !illegal_q && !FLUSH && !RST;
  assign CSR_RADDR    = addr_q;
  assign CSR_WADDR    = write_fire ? addr_q : 12'd0;
  assign CSR_WDATA    = write_fire ? new_val : 32'd0;
  assign RESP_VALID   = (state_q == ST_RESP) && !FLUSH && !RST;
  assign RESP_RD_ADDR = rd_q;
  assign RESP_RD_DATA = ((state_q == ST_RESP) && !illegal_q) ? old_q : 32'd0;
  assign RESP_ILLEGAL = (state_q == ST_RESP) && illegal_q;

  // State register, request capture on accept, and old-value capture in WRITE
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'd0;
      addr_q    <= 12'd0;
      src_q     <= 32'd0;
      rd_q      <= 5'd0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= REQ_OP;
        addr_q    <= REQ_CSR_ADDR;
        src_q     <= req_src;
        rd_q      <= REQ_RD_ADDR;
        wen_q     <= req_wen;
        illegal_q <= req_illegal;
      end
      if (state_q == ST_WRITE) begin
        old_q <= CSR_RDATA_REG;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: drives csr_access_unit against a simple registered-read
// CSR file and compares every transaction with a request-level model.
module tb_csr_access_unit;

  typedef struct packed {
    logic [1:0]  op;
    logic        use_imm;
    logic [11:0] addr;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  uimm;
    logic [4:0]  rd;
  } req_t;

  typedef struct packed {
    req_t        req;
    logic [11:0] ewaddr;
    logic [31:0] ewdata;
    logic [31:0] erd;
    logic        eill;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_OP;
  logic        REQ_USE_IMM;
  logic [11:0] REQ_CSR_ADDR;
  logic [4:0]  REQ_RS1_ADDR;
  logic [31:0] REQ_RS1_DATA;
  logic [4:0]  REQ_UIMM;
  logic [4:0]  REQ_RD_ADDR;
  logic [11:0] CSR_RADDR;
  logic [31:0] CSR_RDATA_REG;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic        RESP_VALID;
  logic [4:0]  RESP_RD_ADDR;
  logic [31:0] RESP_RD_DATA;
  logic        RESP_ILLEGAL;

  logic [31:0] env_mem   [0:4095];
  logic [31:0] model_mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  int checks   = 0;
  int failures = 0;

  csr_access_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .FLUSH        (FLUSH),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_OP       (REQ_OP),
    .REQ_USE_IMM  (REQ_USE_IMM),
    .REQ_CSR_ADDR (REQ_CSR_ADDR),
    .REQ_RS1_ADDR (REQ_RS1_ADDR),
    .REQ_RS1_DATA (REQ_RS1_DATA),
    .REQ_UIMM     (REQ_UIMM),
    .REQ_RD_ADDR  (REQ_RD_ADDR),
    .CSR_RADDR    (CSR_RADDR),
    .CSR_RDATA_REG(CSR_RDATA_REG),
    .CSR_WADDR    (CSR_WADDR),
    .CSR_WDATA    (CSR_WDATA),
    .RESP_VALID   (RESP_VALID),
    .RESP_RD_ADDR (RESP_RD_ADDR),
    .RESP_RD_DATA (RESP_RD_DATA),
    .RESP_ILLEGAL (RESP_ILLEGAL)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // CSR file stand-in: registered read, write on the edge, plus a backdoor for preloading
  always @(posedge CLK) begin
    CSR_RDATA_REG <= env_mem[CSR_RADDR];
    if (pl_en) env_mem[pl_addr] <= pl_data;
    else if (CSR_WADDR != 12'd0) env_mem[CSR_WADDR] <= CSR_WDATA;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mkReq(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                                 input logic [4:0] rs1a, input logic [31:0] rs1d,
                                 input logic [4:0] uimm, input logic [4:0] rd);
    req_t r;
    r.op = op; r.use_imm = imm; r.addr = addr; r.rs1_addr = rs1a;
    r.rs1_data = rs1d; r.uimm = uimm; r.rd = rd;
    return r;
  endfunction

  // Request-level model: decides legality from address sets and applies the write to model_mem
  task automatic modelReq(input req_t r, output logic [11:0] ewaddr, output logic [31:0] ewdata,
                          output logic [31:0] erd, output logic eill);
    logic [31:0] src;
    logic [31:0] old;
    logic [31:0] nv;
    logic        wen;
    logic        isRw;
    logic        isRo;
    src  = r.use_imm ? {27'b0, r.uimm} : r.rs1_data;
    wen  = (r.op == 2'b01) || (r.use_imm ? (r.uimm != 0) : (r.rs1_addr != 0));
    isRw = r.addr inside {12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
    isRo = r.addr inside {12'hB00, 12'hB80, 12'hB02, 12'hB82};
    eill = (r.op == 2'b00) || !(isRw || isRo) || (wen && isRo);
    old  = (isRw || isRo) ? model_mem[r.addr] : 32'd0;
    if (r.op == 2'b01)      nv = src;
    else if (r.op == 2'b10) nv = old | src;
    else                    nv = old & ~src;
    if (!eill && wen) begin
      ewaddr = r.addr;
      ewdata = nv;
      model_mem[r.addr] = nv;
    end else begin
      ewaddr = 12'd0;
      ewdata = 32'd0;
    end
    erd = eill ? 32'd0 : old;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    @(negedge CLK);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    model_mem[addr] = data;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  task automatic driveReq(input req_t r);
    REQ_OP = r.op; REQ_USE_IMM = r.use_imm; REQ_CSR_ADDR = r.addr;
    REQ_RS1_ADDR = r.rs1_addr; REQ_RS1_DATA = r.rs1_data; REQ_UIMM = r.uimm;
    REQ_RD_ADDR = r.rd;
  endtask

  // One full request: accept, then check READ, WRITE and RESP cycles
  task automatic applyStimulus(input req_t r, input logic [11:0] ewaddr, input logic [31:0] ewdata,
                               input logic [31:0] erd, input logic eill);
    int waitCycles;
    waitCycles = 0;
    @(negedge CLK);
    while (!REQ_READY && waitCycles < 20) begin
      @(negedge CLK);
      waitCycles++;
    end
    checkOutput("ready_at_accept", 32'(REQ_READY), 32'd1);
    driveReq(r);
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checkOutput("read_ready", 32'(REQ_READY), 32'd0);
    checkOutput("read_raddr", 32'(CSR_RADDR), 32'(r.addr));
    checkOutput("read_waddr", 32'(CSR_WADDR), 32'd0);
    checkOutput("read_resp_valid", 32'(RESP_VALID), 32'd0);
    @(negedge CLK);
    checkOutput("write_ready", 32'(REQ_READY), 32'd0);
    checkOutput("write_waddr", 32'(CSR_WADDR), 32'(ewaddr));
    if (ewaddr != 12'd0) checkOutput("write_wdata", CSR_WDATA, ewdata);
    checkOutput("write_resp_valid", 32'(RESP_VALID), 32'd0);
    @(negedge CLK);
    checkOutput("resp_ready", 32'(REQ_READY), 32'd0);
    checkOutput("resp_valid", 32'(RESP_VALID), 32'd1);
    checkOutput("resp_rd_addr", 32'(RESP_RD_ADDR), 32'(r.rd));
    checkOutput("resp_rd_data", RESP_RD_DATA, erd);
    checkOutput("resp_illegal", 32'(RESP_ILLEGAL), 32'(eill));
    checkOutput("resp_waddr", 32'(CSR_WADDR), 32'd0);
  endtask

  task automatic modelTransaction(input req_t r);
    logic [11:0] ewaddr;
    logic [31:0] ewdata;
    logic [31:0] erd;
    logic        eill;
    modelReq(r, ewaddr, ewdata, erd, eill);
    applyStimulus(r, ewaddr, ewdata, erd, eill);
  endtask

  vec_t        vecs [11];
  logic [11:0] addrList [10];
  logic [11:0] dw;
  logic [31:0] dd;
  logic [31:0] drd;
  logic        dill;
  req_t        r;

  // Main test sequence
  initial begin
    RST = 1'b1; FLUSH = 1'b0; REQ_VALID = 1'b0; pl_en = 1'b0; pl_addr = 12'd0; pl_data = 32'd0;
    driveReq(mkReq(2'b00, 1'b0, 12'h000, 5'd0, 32'd0, 5'd0, 5'd0));

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("rst_ready", 32'(REQ_READY), 32'd0);
    checkOutput("rst_raddr", 32'(CSR_RADDR), 32'd0);
    checkOutput("rst_waddr", 32'(CSR_WADDR), 32'd0);
    checkOutput("rst_wdata", CSR_WDATA, 32'd0);
    checkOutput("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    checkOutput("rst_resp_rd_addr", 32'(RESP_RD_ADDR), 32'd0);
    checkOutput("rst_resp_rd_data", RESP_RD_DATA, 32'd0);
    checkOutput("rst_resp_illegal", 32'(RESP_ILLEGAL), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("post_rst_ready", 32'(REQ_READY), 32'd1);
    checkOutput("post_rst_waddr", 32'(CSR_WADDR), 32'd0);
    checkOutput("post_rst_resp_valid", 32'(RESP_VALID), 32'd0);

    // Directed table
    preload(12'h340, 32'h0000_00F0);
    preload(12'h343, 32'h0000_000F);
    preload(12'hB00, 32'hCAFE_0001);
    preload(12'h305, 32'h0000_0100);
    preload(12'hB02, 32'h0000_0055);
    preload(12'hB80, 32'h0000_0777);
    preload(12'hB82, 32'h0000_0999);
    vecs[0]  = '{mkReq(2'b01, 1'b0, 12'h340, 5'd5, 32'h1234_5678, 5'd0, 5'd1), 12'h340, 32'h1234_5678, 32'h0000_00F0, 1'b0};
    vecs[1]  = '{mkReq(2'b10, 1'b1, 12'h343, 5'd0, 32'h0, 5'h10, 5'd2), 12'h343, 32'h0000_001F, 32'h0000_000F, 1'b0};
    vecs[2]  = '{mkReq(2'b11, 1'b0, 12'h343, 5'd6, 32'h3, 5'd0, 5'd3), 12'h343, 32'h0000_001C, 32'h0000_001F, 1'b0};
    vecs[3]  = '{mkReq(2'b10, 1'b0, 12'hB00, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd4), 12'h000, 32'h0, 32'hCAFE_0001, 1'b0};
    vecs[4]  = '{mkReq(2'b01, 1'b0, 12'hB02, 5'd7, 32'h1, 5'd0, 5'd5), 12'h000, 32'h0, 32'h0, 1'b1};
    vecs[5]  = '{mkReq(2'b10, 1'b0, 12'h7C0, 5'd0, 32'h0, 5'd0, 5'd6), 12'h000, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{mkReq(2'b00, 1'b0, 12'h340, 5'd3, 32'h5, 5'd0, 5'd7), 12'h000, 32'h0, 32'h0, 1'b1};
    vecs[7]  = '{mkReq(2'b10, 1'b0, 12'h340, 5'd0, 32'h0, 5'd0, 5'd0), 12'h000, 32'h0, 32'h1234_5678, 1'b0};
    vecs[8]  = '{mkReq(2'b11, 1'b1, 12'hB80, 5'd9, 32'h0, 5'd0, 5'd8), 12'h000, 32'h0, 32'h0000_0777, 1'b0};
    vecs[9]  = '{mkReq(2'b01, 1'b0, 12'h305, 5'd0, 32'h8000_0001, 5'd0, 5'd9), 12'h305, 32'h8000_0001, 32'h0000_0100, 1'b0};
    vecs[10] = '{mkReq(2'b10, 1'b1, 12'hB82, 5'd0, 32'h0, 5'd1, 5'd10), 12'h000, 32'h0, 32'h0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      modelReq(vecs[i].req, dw, dd, drd, dill);
      applyStimulus(vecs[i].req, vecs[i].ewaddr, vecs[i].ewdata, vecs[i].erd, vecs[i].eill);
    end

    // Flush in the WRITE cycle of a CSRRW to 0x305
    @(negedge CLK);
    driveReq(mkReq(2'b01, 1'b0, 12'h305, 5'd4, 32'h0000_ABCD, 5'd0, 5'd11));
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    FLUSH = 1'b1;
    #1;
    checkOutput("flush_waddr", 32'(CSR_WADDR), 32'd0);
    checkOutput("flush_ready", 32'(REQ_READY), 32'd0);
    checkOutput("flush_resp_valid", 32'(RESP_VALID), 32'd0);
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    checkOutput("after_flush_ready", 32'(REQ_READY), 32'd1);
    checkOutput("after_flush_resp_valid", 32'(RESP_VALID), 32'd0);
    modelTransaction(mkReq(2'b10, 1'b0, 12'h305, 5'd0, 32'h0, 5'd0, 5'd12));

    // Reset during READ abandons the request
    @(negedge CLK);
    driveReq(mkReq(2'b01, 1'b0, 12'h340, 5'd9, 32'h5A5A_5A5A, 5'd0, 5'd13));
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("midrst_ready", 32'(REQ_READY), 32'd0);
    checkOutput("midrst_waddr", 32'(CSR_WADDR), 32'd0);
    checkOutput("midrst_raddr", 32'(CSR_RADDR), 32'd0);
    checkOutput("midrst_resp_valid", 32'(RESP_VALID), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_after_ready", 32'(REQ_READY), 32'd1);
    checkOutput("midrst_after_waddr", 32'(CSR_WADDR), 32'd0);
    modelTransaction(mkReq(2'b10, 1'b0, 12'h340, 5'd0, 32'h0, 5'd0, 5'd14));

    // Back-to-back with REQ_VALID held high
    @(negedge CLK);
    r = mkReq(2'b10, 1'b0, 12'h340, 5'd0, 32'h0, 5'd0, 5'd15);
    driveReq(r);
    REQ_VALID = 1'b1;
    for (int c = 0; c < 12; c++) begin
      checkOutput("b2b_ready", 32'(REQ_READY), ((c % 4) == 0) ? 32'd1 : 32'd0);
      checkOutput("b2b_resp_valid", 32'(RESP_VALID), ((c % 4) == 3) ? 32'd1 : 32'd0);
      if ((c % 4) == 3) checkOutput("b2b_rd_data", RESP_RD_DATA, model_mem[12'h340]);
      @(negedge CLK);
    end
    REQ_VALID = 1'b0;

    // Randomized requests against the model
    addrList[0] = 12'h305; addrList[1] = 12'h340; addrList[2] = 12'h341; addrList[3] = 12'h342;
    addrList[4] = 12'h343; addrList[5] = 12'hB00; addrList[6] = 12'hB80; addrList[7] = 12'hB02;
    addrList[8] = 12'hB82; addrList[9] = 12'h7C0;
    for (int i = 0; i < 9; i++) preload(addrList[i], $urandom);
    for (int i = 0; i < 60; i++) begin
      r.op       = 2'($urandom_range(0, 3));
      r.use_imm  = 1'($urandom_range(0, 1));
      r.addr     = ($urandom_range(0, 10) == 10) ? 12'($urandom) : addrList[$urandom_range(0, 9)];
      r.rs1_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.rs1_data = $urandom;
      r.uimm     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.rd       = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      modelTransaction(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
